// File: rtl/spi_cpu_bridge_if.sv
// CPU register bus plus SPI core handshake, grouped for the bridge.
interface spi_cpu_bridge_if;
  logic        cpu_wr;
  logic        cpu_rd;
  logic [1:0]  cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        irq;
  logic [7:0]  core_cfg;
  logic        core_start;
  logic [15:0] core_tx;
  logic        core_done;
  logic [15:0] core_rx;

  modport slave (
    input  cpu_wr, cpu_rd, cpu_addr, cpu_wdata, core_done, core_rx,
    output cpu_rdata, irq, core_cfg, core_start, core_tx
  );

  modport master (
    output cpu_wr, cpu_rd, cpu_addr, cpu_wdata, core_done, core_rx,
    input  cpu_rdata, irq, core_cfg, core_start, core_tx
  );
endinterface

// File: rtl/spi_cpu_bridge.sv
// CPU front end for the SPI core: register decode, TX/RX byte FIFOs,
// 8/16-bit frame assembly and the start/done handshake.
module spi_cpu_bridge #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic              clk,
  input  logic              rst,
  spi_cpu_bridge_if.slave   bus
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_START, S_WAIT, S_STORE} state_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  state_t      state, state_nx;
  logic        phase;
  logic        len;
  logic [AW:0] need;

  logic [7:0]  core_cfg_r, cpu_rdata_r;
  logic [15:0] core_tx_r, rx_buf;
  logic        cfg_valid, tx_ovf, rx_ovf, irq_r;

  logic [7:0]  tx_mem [DEPTH];
  logic [7:0]  rx_mem [DEPTH];
  logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic [AW:0] tx_count, rx_count;
  logic        tx_full, tx_empty, rx_full, rx_empty;
  logic        tx_push_req, tx_push, tx_pop;
  logic        rx_push_req, rx_push, rx_pop;
  logic        core_start;
  logic [7:0]  rx_byte, status;

  assign len  = core_cfg_r[6];
  assign need = len ? (AW+1)'(2) : (AW+1)'(1);

  assign tx_full  = (tx_count == FULL_CNT);
  assign tx_empty = (tx_count == '0);
  assign rx_full  = (rx_count == FULL_CNT);
  assign rx_empty = (rx_count == '0);

  // A same-cycle pop frees a slot, so a push into a full FIFO still lands.
  assign tx_push_req = bus.cpu_wr && bus.cpu_addr == 2'd1;
  assign tx_push     = tx_push_req && (!tx_full || tx_pop);
  assign rx_pop      = bus.cpu_rd && bus.cpu_addr == 2'd2 && !rx_empty;
  assign rx_push     = rx_push_req && (!rx_full || rx_pop);

  assign rx_byte = (len && !phase) ? rx_buf[15:8] : rx_buf[7:0];
  assign status  = {cfg_valid, state != S_IDLE, rx_ovf, tx_ovf,
                    rx_full, rx_empty, tx_full, tx_empty};

  always_comb begin
    state_nx    = state;
    tx_pop      = 1'b0;
    rx_push_req = 1'b0;
    core_start  = 1'b0;
    case (state)
      S_IDLE:  if (cfg_valid && tx_count >= need) state_nx = S_FETCH;
      S_FETCH: begin
        tx_pop = 1'b1;
        if (phase == len) state_nx = S_START;
      end
      S_START: begin
        core_start = 1'b1;
        state_nx   = S_WAIT;
      end
      S_WAIT:  if (bus.core_done) state_nx = S_STORE;
      S_STORE: begin
        rx_push_req = 1'b1;
        if (phase == len) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      phase <= 1'b0;
    end else begin
      state <= state_nx;
      if (state_nx != state)                      phase <= 1'b0;
      else if (state == S_FETCH || state == S_STORE) phase <= ~phase;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      core_tx_r <= '0;
      rx_buf    <= '0;
    end else begin
      if (state == S_FETCH) begin
        if (!phase) core_tx_r <= len ? {tx_mem[tx_rp], 8'h00} : {8'h00, tx_mem[tx_rp]};
        else        core_tx_r[7:0] <= tx_mem[tx_rp];
      end
      if (state == S_WAIT && bus.core_done) rx_buf <= bus.core_rx;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= bus.cpu_wdata;
    if (rx_push) rx_mem[rx_wp] <= rx_byte;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_wp <= '0; tx_rp <= '0; tx_count <= '0;
      rx_wp <= '0; rx_rp <= '0; rx_count <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      tx_count <= tx_count + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
      rx_count <= rx_count + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      core_cfg_r  <= '0;
      cfg_valid   <= 1'b0;
      tx_ovf      <= 1'b0;
      rx_ovf      <= 1'b0;
      cpu_rdata_r <= '0;
      irq_r       <= 1'b0;
    end else begin
      if (bus.cpu_wr && bus.cpu_addr == 2'd0 && state == S_IDLE) begin
        core_cfg_r <= bus.cpu_wdata;
        cfg_valid  <= 1'b1;
      end
      if (bus.cpu_wr && bus.cpu_addr == 2'd3) begin
        if (bus.cpu_wdata[4]) tx_ovf <= 1'b0;
        if (bus.cpu_wdata[5]) rx_ovf <= 1'b0;
      end
      // Overflow events win over a clear landing in the same cycle.
      if (tx_push_req && !tx_push) tx_ovf <= 1'b1;
      if (rx_push_req && !rx_push) rx_ovf <= 1'b1;
      if (bus.cpu_rd) begin
        case (bus.cpu_addr)
          2'd0:    cpu_rdata_r <= core_cfg_r;
          2'd1:    cpu_rdata_r <= 8'h00;
          2'd2:    cpu_rdata_r <= rx_empty ? 8'h00 : rx_mem[rx_rp];
          default: cpu_rdata_r <= status;
        endcase
      end
      irq_r <= core_cfg_r[0] & (~rx_empty | tx_ovf | rx_ovf);
    end
  end

  assign bus.cpu_rdata  = cpu_rdata_r;
  assign bus.irq        = irq_r;
  assign bus.core_cfg   = core_cfg_r;
  assign bus.core_start = core_start;
  assign bus.core_tx    = core_tx_r;
endmodule
